// File: rtl/shift_add_mult.sv
// Unsigned sequential shift-and-add multiplier (go/busy/done handshake).
// Latency: W cycles of busy, then a one-cycle done pulse (fewer with EARLY_EXIT).
// Backpressure: none; go is only sampled in IDLE and ignored otherwise.
module shift_add_mult #(
  parameter int W          = 4,
  parameter int CW         = 3,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic [2*W-1:0]  p,
  output logic            done,
  output logic            busy,
  output logic [CW-1:0]   cnt_out
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t          state;
  logic [2*W-1:0]  a_sh;     // multiplicand, shifted left each iteration
  logic [W-1:0]    b_sh;     // multiplier, shifted right each iteration
  logic [CW-1:0]   cnt;      // remaining iterations

  logic [CW-1:0]   cnt_dec;
  logic [W-1:0]    b_next;
  logic            last_iter;

  // Next-iteration values used to decide whether this ITER cycle is the last one
  assign cnt_dec   = cnt - 1'b1;
  assign b_next    = b_sh >> 1;
  assign last_iter = (cnt_dec == '0) || (EARLY_EXIT && (b_next == '0));

  assign cnt_out = cnt;

  // Control FSM and datapath; busy/done are registered Moore outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      cnt   <= '0;
      p     <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            a_sh <= {{W{1'b0}}, a};
            b_sh <= b;
            p    <= '0;
            cnt  <= CW'(W);
            // A zero multiplier needs no iterations when early exit is enabled
            if (EARLY_EXIT && (b == '0)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ITER;
              busy  <= 1'b1;
            end
          end
        end
        ITER: begin
          if (b_sh[0]) begin
            p <= p + a_sh;
          end
          a_sh <= a_sh << 1;
          b_sh <= b_next;
          cnt  <= cnt_dec;
          if (last_iter) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
